// File: rtl/clus_ofc_err_pkg.sv
// ---------------------------------------------------------------------------
// clus_ofc_err_pkg
// Shared types and defaults for the cluster serial error receiver.
//   state_t     : per-channel receive FSM states (HUNT/CAPT/PAR/DONE)
//   DEF_*       : default frame geometry (payload length, header width/pattern)
//   CNT_W       : width of the per-channel payload bit counter
//   bus_offset  : LSB position of a channel's slice in the flat output bus
// ---------------------------------------------------------------------------
package clus_ofc_err_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        CAPT = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int                   DEF_LENGTH_ERR = 18;
    localparam int                   DEF_HDR_W      = 3;
    localparam logic [DEF_HDR_W-1:0] DEF_HDR        = 3'b100;

    // The payload counter is 5 bits wide, so a payload is at most 31 bits.
    localparam int                   CNT_W          = 5;

    function automatic int bus_offset(input int ch, input int len);
        return ch * len;
    endfunction

endpackage

// File: rtl/clus_ofc_err_rx_if.sv
// ---------------------------------------------------------------------------
// clus_ofc_err_rx_if
// Bundle of the serial error inputs and the cluster status outputs.
//   in_live      : link live; low re-arms every channel
//   in_err       : one serial error bit per channel per clock
//   bypass       : force all completion flags high (sticky)
//   rearm        : per-channel pulse, leave DONE and hunt again
//   got_err      : per-channel frame-complete flag
//   all_got      : registered AND of got_err
//   out_err_bus  : captured payloads, channel c at [c*LENGTH_ERR +: LENGTH_ERR]
//   par_err      : per-channel parity error (zero unless parity is built in)
// master drives the inputs (link side), slave is the receiver.
// ---------------------------------------------------------------------------
interface clus_ofc_err_rx_if
    import clus_ofc_err_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int LENGTH_ERR = DEF_LENGTH_ERR
);
    logic                      in_live;
    logic [NCH-1:0]            in_err;
    logic                      bypass;
    logic [NCH-1:0]            rearm;
    logic [NCH-1:0]            got_err;
    logic                      all_got;
    logic [NCH*LENGTH_ERR-1:0] out_err_bus;
    logic [NCH-1:0]            par_err;

    modport master (
        output in_live, in_err, bypass, rearm,
        input  got_err, all_got, out_err_bus, par_err
    );

    modport slave (
        input  in_live, in_err, bypass, rearm,
        output got_err, all_got, out_err_bus, par_err
    );
endinterface

// File: rtl/clus_ofc_err_chan.sv
// ---------------------------------------------------------------------------
// clus_ofc_err_chan
// One serial error channel: header hunt, payload deserialiser, done flag and
// (optionally) trailing even-parity check.
// Optional feature macro: CLUS_OFC_ERR_PARITY_EN adds the PAR state, which
// samples one trailing parity bit and delays the done flag by one clock.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   live       : low = synchronous clear of everything (highest priority)
//   ser_in     : serial error bit for this channel
//   force_got  : bypass, sets got high (sticky)
//   rearm      : leave DONE and hunt again; also drops got / par_err
//   got        : frame complete
//   word       : captured payload, bit 0 is the first payload bit received
//   par_err    : parity mismatch of the last frame
// ---------------------------------------------------------------------------
module clus_ofc_err_chan
    import clus_ofc_err_pkg::*;
#(
    parameter int                LENGTH_ERR = DEF_LENGTH_ERR,
    parameter int                HDR_W      = DEF_HDR_W,
    parameter logic [HDR_W-1:0]  HDR        = DEF_HDR
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  live,
    input  logic                  ser_in,
    input  logic                  force_got,
    input  logic                  rearm,
    output logic                  got,
    output logic [LENGTH_ERR-1:0] word,
    output logic                  par_err
);

    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(LENGTH_ERR);

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [HDR_W-1:0]      hsr_reg;
    logic                  got_reg;
    logic [LENGTH_ERR-1:0] word_reg;

    logic                  hdr_hit;
    logic                  sample_en;
    logic [CNT_W-1:0]      sample_idx;
    logic                  got_set;

    always_comb begin
        // Header compare uses the register contents before this edge's shift.
        hdr_hit    = (hsr_reg == HDR);
        sample_en  = 1'b0;
        sample_idx = cnt_reg;
        got_set    = 1'b0;
        case (state_reg)
            HUNT: begin
                // The bit arriving with the matching header is payload bit 0.
                sample_en  = hdr_hit;
                sample_idx = '0;
            end
            CAPT: begin
                sample_en = (cnt_reg != LEN_CNT);
`ifndef CLUS_OFC_ERR_PARITY_EN
                got_set   = (cnt_reg == LEN_CNT);
`endif
            end
`ifdef CLUS_OFC_ERR_PARITY_EN
            PAR: begin
                got_set = 1'b1;
            end
`endif
            default: begin
                sample_en = 1'b0;
            end
        endcase
    end

    // FSM, counter, header shift register and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HUNT;
            cnt_reg   <= '0;
            hsr_reg   <= '0;
            got_reg   <= 1'b0;
        end else if (!live) begin
            state_reg <= HUNT;
            cnt_reg   <= '0;
            hsr_reg   <= '0;
            got_reg   <= 1'b0;
        end else begin
            hsr_reg <= {hsr_reg[HDR_W-2:0], ser_in};

            case (state_reg)
                HUNT: begin
                    if (hdr_hit) begin
                        state_reg <= CAPT;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                CAPT: begin
                    // Headers recurring inside the payload are not looked at.
                    if (cnt_reg == LEN_CNT) begin
`ifdef CLUS_OFC_ERR_PARITY_EN
                        state_reg <= PAR;
`else
                        state_reg <= DONE;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`ifdef CLUS_OFC_ERR_PARITY_EN
                PAR: begin
                    state_reg <= DONE;
                end
`endif
                DONE: begin
                    // Only a finished frame reacts to rearm; a running one completes.
                    if (rearm) begin
                        state_reg <= HUNT;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= HUNT;
                    cnt_reg   <= '0;
                end
            endcase

            // Bypass wins, then frame completion, then rearm.
            if (force_got) begin
                got_reg <= 1'b1;
            end else if (got_set) begin
                got_reg <= 1'b1;
            end else if (rearm) begin
                got_reg <= 1'b0;
            end
        end
    end

    // Payload bits: each bit loads only when the counter points at it, so the
    // word holds its old contents after rearm until overwritten.
    genvar gi;
    generate
        for (gi = 0; gi < LENGTH_ERR; gi++) begin : g_bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg[gi] <= 1'b0;
                end else if (!live) begin
                    word_reg[gi] <= 1'b0;
                end else if (sample_en && (sample_idx == CNT_W'(gi))) begin
                    word_reg[gi] <= ser_in;
                end
            end
        end
    endgenerate

`ifdef CLUS_OFC_ERR_PARITY_EN
    logic par_err_reg;

    // Even parity: payload XOR parity bit must be zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_reg <= 1'b0;
        end else if (!live) begin
            par_err_reg <= 1'b0;
        end else if (state_reg == PAR) begin
            par_err_reg <= (^word_reg) ^ ser_in;
        end else if (rearm) begin
            par_err_reg <= 1'b0;
        end
    end

    assign par_err = par_err_reg;
`else
    assign par_err = 1'b0;
`endif

    assign got  = got_reg;
    assign word = word_reg;

endmodule

// File: rtl/clus_ofc_err_rx.sv
// ---------------------------------------------------------------------------
// clus_ofc_err_rx
// Multi-channel receiver for the serial TLK error streams of the fanout CDT
// cluster. Each channel hunts a header and deserialises a fixed-length error
// word; the top fans out live/bypass and builds the registered all_got flag.
// Optional feature macro: CLUS_OFC_ERR_PARITY_EN (trailing even-parity bit,
// par_err outputs); without it par_err is constant zero.
// Ports:
//   clk   : system clock, all logic on posedge
//   rst   : asynchronous reset, active-high
//   link  : clus_ofc_err_rx_if.slave (in_live, in_err, bypass, rearm,
//           got_err, all_got, out_err_bus, par_err)
// ---------------------------------------------------------------------------
module clus_ofc_err_rx
    import clus_ofc_err_pkg::*;
#(
    parameter int               NCH        = 4,
    parameter int               LENGTH_ERR = DEF_LENGTH_ERR,
    parameter int               HDR_W      = DEF_HDR_W,
    parameter logic [HDR_W-1:0] HDR        = DEF_HDR
)(
    input  logic             clk,
    input  logic             rst,
    clus_ofc_err_rx_if.slave link
);

    logic [NCH-1:0]            got_w;
    logic [NCH-1:0]            par_w;
    logic [NCH*LENGTH_ERR-1:0] bus_w;
    logic                      all_got_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            clus_ofc_err_chan #(
                .LENGTH_ERR (LENGTH_ERR),
                .HDR_W      (HDR_W),
                .HDR        (HDR)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .live      (link.in_live),
                .ser_in    (link.in_err[gi]),
                .force_got (link.bypass),
                .rearm     (link.rearm[gi]),
                .got       (got_w[gi]),
                .word      (bus_w[bus_offset(gi, LENGTH_ERR) +: LENGTH_ERR]),
                .par_err   (par_w[gi])
            );
        end
    endgenerate

    // One clock behind the last channel to complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_got_reg <= 1'b0;
        end else if (!link.in_live) begin
            all_got_reg <= 1'b0;
        end else begin
            all_got_reg <= &got_w;
        end
    end

    assign link.got_err     = got_w;
    assign link.par_err     = par_w;
    assign link.out_err_bus = bus_w;
    assign link.all_got     = all_got_reg;

endmodule

// File: tb/tb_clus_ofc_err_rx.sv
// ---------------------------------------------------------------------------
// tb_clus_ofc_err_rx
// Bench for clus_ofc_err_rx. A stream-level reference model keeps the bits
// received since the last clear and derives, per channel, where the frame
// starts, which bits form the payload and when completion is due.
// ---------------------------------------------------------------------------
module tb_clus_ofc_err_rx;
    import clus_ofc_err_pkg::*;

    localparam int               NCH = 4;
    localparam int               L   = DEF_LENGTH_ERR;
    localparam int               HW  = DEF_HDR_W;
    localparam logic [HW-1:0]    HDR = DEF_HDR;
`ifdef CLUS_OFC_ERR_PARITY_EN
    localparam int               FE     = L + 1;
    localparam bit               PAR_EN = 1'b1;
`else
    localparam int               FE     = L;
    localparam bit               PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clus_ofc_err_rx_if #(.NCH(NCH), .LENGTH_ERR(L)) link ();

    clus_ofc_err_rx #(
        .NCH        (NCH),
        .LENGTH_ERR (L),
        .HDR_W      (HW),
        .HDR        (HDR)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NCH-1:0] hist_q[$];     // in_err vector of every live edge since clear
    int             fstart[NCH];   // edge index of payload bit 0, -1 = hunting
    logic [L-1:0]   word_m[NCH];
    logic [NCH-1:0] got_m;
    logic [NCH-1:0] par_m;
    logic           all_m;

    function automatic logic hbit(input int i, input int c);
        if (i < 0) return 1'b0;
        return hist_q[i][c];
    endfunction

    task automatic model_clear();
        hist_q.delete();
        for (int c = 0; c < NCH; c++) begin
            fstart[c] = -1;
            word_m[c] = '0;
        end
        got_m = '0;
        par_m = '0;
        all_m = 1'b0;
    endtask

    task automatic model_edge();
        logic [NCH-1:0] got_prev;
        logic [HW-1:0]  seen;
        int             n;
        bit             was_done;
        bit             got_set;
        if (!link.in_live) begin
            model_clear();
            return;
        end
        got_prev = got_m;
        n = hist_q.size();
        hist_q.push_back(link.in_err);
        for (int c = 0; c < NCH; c++) begin
            was_done = (fstart[c] >= 0) && (n > fstart[c] + FE);
            if (fstart[c] < 0) begin
                for (int i = 0; i < HW; i++) seen[HW-1-i] = hbit(n - HW + i, c);
                if (seen == HDR) fstart[c] = n;
            end
            got_set = 1'b0;
            if (fstart[c] >= 0) begin
                if (n - fstart[c] < L) word_m[c][n - fstart[c]] = link.in_err[c];
                got_set = (n == fstart[c] + FE);
            end
            if (PAR_EN && got_set)    par_m[c] = (^word_m[c]) ^ link.in_err[c];
            else if (link.rearm[c])   par_m[c] = 1'b0;
            if (link.bypass)          got_m[c] = 1'b1;
            else if (got_set)         got_m[c] = 1'b1;
            else if (link.rearm[c])   got_m[c] = 1'b0;
            if (was_done && link.rearm[c]) fstart[c] = -1;
        end
        all_m = &got_prev;
    endtask

    task automatic compare_all();
        logic [NCH*L-1:0] exp_bus;
        for (int c = 0; c < NCH; c++) exp_bus[c*L +: L] = word_m[c];
        check("got_err", link.got_err, got_m);
        check("all_got", link.all_got, all_m);
        check("err_bus", link.out_err_bus, exp_bus);
        check("par_err", link.par_err, par_m);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [NCH-1:0] err, input logic [NCH-1:0] rr,
                         input logic byp, input logic live);
        link.in_err  = err;
        link.rearm   = rr;
        link.bypass  = byp;
        link.in_live = live;
        tick();
    endtask

    task automatic do_rst();
        rst = 1'b1;
        #1;
        model_clear();
        check("rst_got", link.got_err, '0);
        check("rst_all", link.all_got, '0);
        check("rst_bus", link.out_err_bus, '0);
        check("rst_par", link.par_err, '0);
        #1;
        rst = 1'b0;
    endtask

    // Quiet line, then rearm; the zeros keep stale bits out of the hunt.
    task automatic rearm_mask(input logic [NCH-1:0] m);
        repeat (4) drive('0, '0, 1'b0, 1'b1);
        drive('0, m, 1'b0, 1'b1);
    endtask

    task automatic send_ch0(input logic [L-1:0] pl, input int nbits);
        for (int i = 0; i < HW; i++) drive(NCH'(HDR[HW-1-i]), '0, 1'b0, 1'b1);
        for (int j = 0; j < nbits; j++) drive(NCH'(pl[j]), '0, 1'b0, 1'b1);
    endtask

    int             off[NCH];
    logic [L-1:0]   pl_c[NCH];
    logic [L-1:0]   pl;
    logic [NCH-1:0] ev;
    logic [NCH-1:0] rr;
    int             pos;
    int             e3;
    logic           prev3;

    initial begin
        link.in_live = 1'b1;
        link.in_err  = '0;
        link.rearm   = '0;
        link.bypass  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_got", link.got_err, '0);
        check("reset_all", link.all_got, '0);
        check("reset_bus", link.out_err_bus, '0);
        check("reset_par", link.par_err, '0);
        rst = 1'b0;
        repeat (3) drive('0, '0, 1'b0, 1'b1);

        // Single frame on ch0, completion timing relative to the last header bit.
        send_ch0(18'h2A5C3, L);
        check("ch0_got_early", link.got_err[0], 1'b0);
        repeat (FE - L + 1) drive('0, '0, 1'b0, 1'b1);
        check("ch0_got", link.got_err, 4'h1);
        check("ch0_word", link.out_err_bus[L-1:0], 18'h2A5C3);
        repeat (3) drive('0, '0, 1'b0, 1'b1);

        // Four channels, staggered starts.
        rearm_mask('1);
        off[0] = 0; off[1] = 3; off[2] = 7; off[3] = 11;
        for (int c = 0; c < NCH; c++) pl_c[c] = L'($urandom);
        e3 = -10;
        for (int t = 0; t < 11 + HW + L + 6; t++) begin
            for (int c = 0; c < NCH; c++) begin
                pos = t - off[c];
                if (pos < 0)           ev[c] = 1'b0;
                else if (pos < HW)     ev[c] = HDR[HW-1-pos];
                else if (pos < HW + L) ev[c] = pl_c[c][pos-HW];
                else                   ev[c] = 1'b0;
            end
            prev3 = link.got_err[3];
            drive(ev, '0, 1'b0, 1'b1);
            if (link.got_err[3] && !prev3) begin
                e3 = t;
                check("all_got_with_ch3", link.all_got, 1'b0);
            end
            if (t == e3 + 1) check("all_got_after_ch3", link.all_got, 1'b1);
        end
        check("ch3_completed", link.got_err, 4'hF);
        for (int c = 0; c < NCH; c++) check("stagger_word", link.out_err_bus[c*L +: L], pl_c[c]);

        // Header pattern inside the payload, then a second header while done.
        rearm_mask(4'h1);
        send_ch0(18'h09249, L);
        repeat (FE - L + 1) drive('0, '0, 1'b0, 1'b1);
        check("embed_word", link.out_err_bus[L-1:0], 18'h09249);
        send_ch0(18'h3FFFF, L);
        repeat (3) drive('0, '0, 1'b0, 1'b1);
        check("done_ignores_hdr", link.out_err_bus[L-1:0], 18'h09249);
        check("done_got", link.got_err[0], 1'b1);

        // Reset in the middle of a frame, then a clean frame.
        rearm_mask(4'h1);
        pl = L'($urandom);
        send_ch0(pl, 9);
        do_rst();
        pl = L'($urandom);
        repeat (3) drive('0, '0, 1'b0, 1'b1);
        send_ch0(pl, L);
        repeat (FE - L + 1) drive('0, '0, 1'b0, 1'b1);
        check("after_rst_word", link.out_err_bus[L-1:0], pl);
        check("after_rst_got", link.got_err, 4'h1);

        // Same with in_live dropped for one edge.
        rearm_mask(4'h1);
        send_ch0(L'($urandom), 9);
        drive('0, '0, 1'b0, 1'b0);
        check("unlive_got", link.got_err, '0);
        check("unlive_bus", link.out_err_bus, '0);
        pl = L'($urandom);
        repeat (3) drive('0, '0, 1'b0, 1'b1);
        send_ch0(pl, L);
        repeat (FE - L + 1) drive('0, '0, 1'b0, 1'b1);
        check("after_unlive_word", link.out_err_bus[L-1:0], pl);

        // Bypass pulse without frames, then rearm on ch0.
        do_rst();
        drive('0, '0, 1'b1, 1'b1);
        check("bypass_got", link.got_err, 4'hF);
        repeat (3) drive('0, '0, 1'b0, 1'b1);
        check("bypass_sticky", link.got_err, 4'hF);
        check("bypass_bus", link.out_err_bus, '0);
        drive('0, 4'h1, 1'b0, 1'b1);
        check("bypass_rearm", link.got_err, 4'hE);

`ifdef CLUS_OFC_ERR_PARITY_EN
        // Parity bit held over both trailing bit times.
        do_rst();
        for (int pb = 0; pb < 2; pb++) begin
            rearm_mask(4'h1);
            send_ch0(18'h00001, L);
            drive(NCH'(pb), '0, 1'b0, 1'b1);
            check("par_got_early", link.got_err[0], 1'b0);
            drive(NCH'(pb), '0, 1'b0, 1'b1);
            check("par_got", link.got_err[0], 1'b1);
            check("par_err0", link.par_err[0], (pb == 0) ? 1'b1 : 1'b0);
        end
`endif

        // Random traffic.
        do_rst();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) rr[c] = ($urandom_range(0, 15) == 0);
            drive(NCH'($urandom), rr, ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 399) != 0));
            if ($urandom_range(0, 599) == 0) do_rst();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
